lvdc_timing_gen: RTL and testbench

Bit-time and phase-time generator for the LVDC, directly downstream of the clock logic. It consumes the per-bit strobe derived from the clock-logic phase outputs and produces one-hot bit-time (BT1–BT14) and phase (P1–P3) decodes for the arithmetic and memory sections. It also produces phase-boundary and cycle-boundary pulses, a wrapping computer-cycle count, and a phase-boundary halt handshake for single-stepping.

---
 rtl/lvdc_timing_pkg.sv | 15 +
 rtl/lvdc_timing_wdog.sv | 42 ++++
 rtl/lvdc_timing_gen.sv | 121 ++++++++++++
 tb/tb_lvdc_timing_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lvdc_timing_pkg.sv
// Shared constants, counter types and halt states for the LVDC bit/phase timing generator.
package lvdc_timing_pkg;

  localparam int unsigned BITS_PER_PHASE = 14;
  localparam int unsigned PHASES         = 3;

  typedef logic [3:0] bt_num_t;
  typedef logic [1:0] ph_num_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } halt_state_t;

endpackage

// File: rtl/lvdc_timing_wdog.sv
// Strobe-interval watchdog: flags irregular bit_strobe spacing or a stalled strobe while running.
// Instantiated by lvdc_timing_gen only when LVDC_TIMING_WDOG_EN is defined.
module lvdc_timing_wdog
  import lvdc_timing_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  input  logic halted,
  input  logic resync,
  output logic timing_err
);

  localparam int unsigned LIMIT = 2 * CLKS_PER_BIT;
  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;
  logic             armed;

  // cnt holds clks elapsed since the last accepted strobe minus one; armed clears
  // whenever the next strobe must be exempt from the interval check.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      armed      <= 1'b0;
      timing_err <= 1'b0;
    end else if (resync || halted) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (adv) begin
      if (armed && (cnt != CNT_W'(CLKS_PER_BIT - 1))) timing_err <= 1'b1;
      armed <= 1'b1;
      cnt   <= '0;
    end else begin
      if (armed && (cnt >= CNT_W'(LIMIT - 1))) timing_err <= 1'b1;
      if (cnt < CNT_W'(LIMIT - 1)) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lvdc_timing_gen.sv
// LVDC bit-time / phase-time generator with cycle count and phase-boundary halt handshake.
// Optional strobe watchdog and timing_err port are built only with LVDC_TIMING_WDOG_EN defined.
module lvdc_timing_gen
  import lvdc_timing_pkg::*;
#(
  parameter int unsigned BITS_PER_PHASE = lvdc_timing_pkg::BITS_PER_PHASE,
  parameter int unsigned PHASES         = lvdc_timing_pkg::PHASES,
  parameter int unsigned CLKS_PER_BIT   = 4,
  parameter int unsigned CYC_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bit_strobe,
  input  logic                      sync,
  input  logic                      hlt_req,
  output logic [BITS_PER_PHASE-1:0] bt,
  output logic [3:0]                bt_num,
  output logic [PHASES-1:0]         ph,
  output logic [1:0]                ph_num,
  output logic                      bit_tick,
  output logic                      phase_end,
  output logic                      cycle_end,
  output logic [CYC_W-1:0]          cycle_cnt,
  output logic                      hlt_ack
`ifdef LVDC_TIMING_WDOG_EN
  ,
  output logic                      timing_err
`endif
);

  if (CLKS_PER_BIT < 1 || BITS_PER_PHASE < 2 || BITS_PER_PHASE > 16 ||
      PHASES < 2 || PHASES > 4) begin : g_bad_params
    $error("lvdc_timing_gen: unsupported parameter set");
  end

  localparam bt_num_t BT_LAST = 4'(BITS_PER_PHASE - 1);
  localparam ph_num_t PH_LAST = 2'(PHASES - 1);

  halt_state_t      state, state_d;
  bt_num_t          bt_d;
  ph_num_t          ph_d;
  logic [CYC_W-1:0] cyc_d;
  logic             tick_d, pend_d, cend_d;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_d;
  end

  // Priority: sync, then halt handling, then strobe advance.
  always_comb begin
    state_d = state;
    bt_d    = bt_num;
    ph_d    = ph_num;
    cyc_d   = cycle_cnt;
    tick_d  = 1'b0;
    pend_d  = 1'b0;
    cend_d  = 1'b0;
    if (sync) begin
      bt_d = '0;
      ph_d = '0;
    end else if (state == HALT) begin
      if (!hlt_req) state_d = RUN;
    end else if (bit_strobe) begin
      tick_d = 1'b1;
      if (bt_num == BT_LAST) begin
        bt_d   = '0;
        pend_d = 1'b1;
        if (hlt_req) state_d = HALT;
        if (ph_num == PH_LAST) begin
          ph_d   = '0;
          cend_d = 1'b1;
          cyc_d  = cycle_cnt + CYC_W'(1);
        end else begin
          ph_d = ph_num + 2'(1);
        end
      end else begin
        bt_d = bt_num + 4'(1);
      end
    end
  end

  // One-hot decodes are taken from the next-count so they stay aligned with bt_num/ph_num.
  always_ff @(posedge clk) begin
    if (rst) begin
      bt_num    <= '0;
      ph_num    <= '0;
      bt        <= BITS_PER_PHASE'(1);
      ph        <= PHASES'(1);
      bit_tick  <= 1'b0;
      phase_end <= 1'b0;
      cycle_end <= 1'b0;
      cycle_cnt <= '0;
      hlt_ack   <= 1'b0;
    end else begin
      bt_num    <= bt_d;
      ph_num    <= ph_d;
      bt        <= BITS_PER_PHASE'(1) << bt_d;
      ph        <= PHASES'(1) << ph_d;
      bit_tick  <= tick_d;
      phase_end <= pend_d;
      cycle_end <= cend_d;
      cycle_cnt <= cyc_d;
      hlt_ack   <= (state_d == HALT);
    end
  end

`ifdef LVDC_TIMING_WDOG_EN
  lvdc_timing_wdog #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .adv       (tick_d),
    .halted    (state == HALT),
    .resync    (sync),
    .timing_err(timing_err)
  );
`endif

endmodule

// File: tb/tb_lvdc_timing_gen.sv
// Self-checking bench for lvdc_timing_gen: position-based reference model plus directed literal checks.
module tb_lvdc_timing_gen;

  localparam int BPP = 14;
  localparam int NPH = 3;
  localparam int CPB = 4;
  localparam int CW  = 5;
  localparam int POS_PER_CYCLE = BPP * NPH;

  logic          clk = 1'b0;
  logic          rst, bit_strobe, sync, hlt_req;
  logic [BPP-1:0] bt;
  logic [3:0]    bt_num;
  logic [NPH-1:0] ph;
  logic [1:0]    ph_num;
  logic          bit_tick, phase_end, cycle_end, hlt_ack;
  logic [CW-1:0] cycle_cnt;
`ifdef LVDC_TIMING_WDOG_EN
  logic          timing_err;
`endif

  always #5 clk = ~clk;

  lvdc_timing_gen #(
    .BITS_PER_PHASE(BPP),
    .PHASES        (NPH),
    .CLKS_PER_BIT  (CPB),
    .CYC_W         (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_strobe(bit_strobe),
    .sync      (sync),
    .hlt_req   (hlt_req),
    .bt        (bt),
    .bt_num    (bt_num),
    .ph        (ph),
    .ph_num    (ph_num),
    .bit_tick  (bit_tick),
    .phase_end (phase_end),
    .cycle_end (cycle_end),
    .cycle_cnt (cycle_cnt),
    .hlt_ack   (hlt_ack)
`ifdef LVDC_TIMING_WDOG_EN
    ,
    .timing_err(timing_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: linear position within a computer cycle (0..41).
  int pos = 0, cyc = 0;
  bit halted = 0, e_tick = 0, e_pe = 0, e_ce = 0, mvalid = 0;

  always @(posedge clk) begin
    e_tick = 0; e_pe = 0; e_ce = 0;
    if (rst) begin
      pos = 0; cyc = 0; halted = 0;
    end else if (sync) begin
      pos = 0;
    end else if (halted) begin
      if (!hlt_req) halted = 0;
    end else if (bit_strobe) begin
      pos    = (pos + 1) % POS_PER_CYCLE;
      e_tick = 1;
      if (pos % BPP == 0) begin
        e_pe = 1;
        if (hlt_req) halted = 1;
      end
      if (pos == 0) begin
        e_ce = 1;
        cyc  = (cyc + 1) % (1 << CW);
      end
    end
    mvalid = 1;
  end

  int pe_seen = 0, ce_seen = 0;

  always @(negedge clk) begin
    if (mvalid) begin
      chk("bt",        32'(bt),        32'(1) << (pos % BPP));
      chk("bt_num",    32'(bt_num),    32'(pos % BPP));
      chk("ph",        32'(ph),        32'(1) << (pos / BPP));
      chk("ph_num",    32'(ph_num),    32'(pos / BPP));
      chk("bit_tick",  32'(bit_tick),  32'(e_tick));
      chk("phase_end", 32'(phase_end), 32'(e_pe));
      chk("cycle_end", 32'(cycle_end), 32'(e_ce));
      chk("cycle_cnt", 32'(cycle_cnt), 32'(cyc));
      chk("hlt_ack",   32'(hlt_ack),   32'(halted));
      if (phase_end) pe_seen++;
      if (cycle_end) ce_seen++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One strobe, then gap-1 quiet clks: consecutive calls space strobes by gap clks.
  task automatic strobe(input int gap);
    bit_strobe = 1'b1;
    idle(1);
    bit_strobe = 1'b0;
    if (gap > 1) idle(gap - 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bit_strobe = 1'b0; sync = 1'b0; hlt_req = 1'b0;
    idle(2);
    chk("rst_bt", 32'(bt), 32'h1);
    chk("rst_ph", 32'(ph), 32'h1);
    chk("rst_cyc", 32'(cycle_cnt), 32'h0);
    chk("rst_ack", 32'(hlt_ack), 32'h0);
    rst = 1'b0;

    // Full computer cycle at nominal spacing.
    pe_seen = 0; ce_seen = 0;
    repeat (42) strobe(4);
    chk("cyc1_pe_count", 32'(pe_seen), 32'd3);
    chk("cyc1_ce_count", 32'(ce_seen), 32'd1);
    chk("cyc1_cnt", 32'(cycle_cnt), 32'd1);
    chk("cyc1_ph", 32'(ph), 32'b001);
    chk("cyc1_bt", 32'(bt), 32'h1);

    // Halt requested mid-phase at BT6 of P1.
    do_reset();
    repeat (5) strobe(4);
    chk("halt_pre_bt", 32'(bt_num), 32'd5);
    hlt_req = 1'b1;
    repeat (12) strobe(4);
    chk("halt_ph", 32'(ph_num), 32'd1);
    chk("halt_bt", 32'(bt_num), 32'd0);
    chk("halt_ack", 32'(hlt_ack), 32'd1);
    hlt_req = 1'b0; bit_strobe = 1'b1;
    idle(1);
    bit_strobe = 1'b0;
    chk("unhalt_ack", 32'(hlt_ack), 32'd0);
    chk("unhalt_bt", 32'(bt_num), 32'd0);
    idle(2);
    strobe(4);
    chk("resume_ph", 32'(ph_num), 32'd1);
    chk("resume_bt", 32'(bt_num), 32'd1);

    // hlt_req dropped before the boundary: no halt.
    hlt_req = 1'b1;
    repeat (3) strobe(4);
    hlt_req = 1'b0;
    repeat (12) strobe(4);
    chk("nohalt_ack", 32'(hlt_ack), 32'd0);
    chk("nohalt_ph", 32'(ph_num), 32'd2);
    chk("nohalt_bt", 32'(bt_num), 32'd2);

    // sync at P3/BT9 of the second cycle with a coincident strobe.
    do_reset();
    repeat (78) strobe(4);
    chk("presync_ph", 32'(ph_num), 32'd2);
    chk("presync_bt", 32'(bt_num), 32'd8);
    sync = 1'b1; bit_strobe = 1'b1;
    idle(1);
    sync = 1'b0; bit_strobe = 1'b0;
    chk("sync_ph", 32'(ph), 32'b001);
    chk("sync_bt", 32'(bt), 32'h1);
    chk("sync_tick", 32'(bit_tick), 32'd0);
    chk("sync_cyc", 32'(cycle_cnt), 32'd1);

    // Reset mid-phase with a coincident strobe.
    repeat (5) strobe(1);
    rst = 1'b1; bit_strobe = 1'b1;
    idle(1);
    rst = 1'b0; bit_strobe = 1'b0;
    chk("midrst_bt", 32'(bt_num), 32'd0);
    chk("midrst_tick", 32'(bit_tick), 32'd0);
    chk("midrst_pe", 32'(phase_end), 32'd0);
    chk("midrst_cyc", 32'(cycle_cnt), 32'd0);

    // Back-to-back strobes up to the cycle_cnt wrap.
    bit_strobe = 1'b1;
    idle(31 * 42);
    bit_strobe = 1'b0;
    idle(2);
    chk("prewrap_cyc", 32'(cycle_cnt), 32'd31);
    bit_strobe = 1'b1;
    idle(41);
    bit_strobe = 1'b0;
    chk("prewrap_ph", 32'(ph_num), 32'd2);
    chk("prewrap_bt", 32'(bt_num), 32'd13);
    ce_seen = 0;
    strobe(2);
    chk("wrap_cyc", 32'(cycle_cnt), 32'd0);
    chk("wrap_ce_count", 32'(ce_seen), 32'd1);

`ifdef LVDC_TIMING_WDOG_EN
    // Short interval after the exempt first strobe.
    do_reset();
    chk("wd_rst", 32'(timing_err), 32'd0);
    strobe(4); strobe(4);
    chk("wd_nominal", 32'(timing_err), 32'd0);
    strobe(3); strobe(4);
    chk("wd_short", 32'(timing_err), 32'd1);
    idle(20);
    chk("wd_sticky", 32'(timing_err), 32'd1);
    do_reset();
    chk("wd_cleared", 32'(timing_err), 32'd0);

    // Stalled strobe in RUN: error exactly 8 clks after the last strobe.
    strobe(4); strobe(7);
    chk("wd_gap7", 32'(timing_err), 32'd0);
    idle(1);
    chk("wd_gap7b", 32'(timing_err), 32'd0);
    idle(1);
    chk("wd_gap8", 32'(timing_err), 32'd1);

    // Long gap while halted is exempt, as is the first strobe after leaving HALT.
    do_reset();
    hlt_req = 1'b1;
    repeat (14) strobe(4);
    chk("wd_halt_ack", 32'(hlt_ack), 32'd1);
    idle(12);
    chk("wd_halt_gap", 32'(timing_err), 32'd0);
    hlt_req = 1'b0;
    idle(3);
    strobe(4); strobe(4);
    chk("wd_after_halt", 32'(timing_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
